// File: rtl/mm_pkg.sv
`default_nettype none
// ============================================================================
// Module   : mm_pkg
// Brief    : Shared constants, state encoding and lane helper for the MV path.
// Revision : 1.0
// ============================================================================
package mm_pkg;

    localparam int c_FP32_W  = 32;
    localparam int c_NUM_DEF = 16;
    localparam int c_DW_DEF  = c_FP32_W;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_COLLECT = 2'd1,
        ST_DRAIN   = 2'd2
    } state_e;

    // Bit offset of lane 'lane' in a packed word of 'dw'-bit lanes.
    function automatic int lane_lsb(input int lane, input int dw);
        return lane * dw;
    endfunction

endpackage
`default_nettype wire

// File: rtl/mv_word_fifo.sv
`default_nettype none
// ============================================================================
// Module   : mv_word_fifo
// Brief    : Synchronous FIFO of packed result words; extra pointer MSB for full.
// Revision : 1.0
// ============================================================================
module mv_word_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_wdata,
    input  logic             i_pop,
    output logic [WIDTH-1:0] o_rdata,
    output logic             o_full,
    output logic             o_empty
);
    localparam int c_AW = $clog2(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [c_AW:0]    r_wr_ptr;
    logic [c_AW:0]    r_rd_ptr;
    logic             w_do_push;
    logic             w_do_pop;

    assign o_empty   = (r_wr_ptr == r_rd_ptr);
    assign o_full    = (r_wr_ptr[c_AW] != r_rd_ptr[c_AW]) &&
                       (r_wr_ptr[c_AW-1:0] == r_rd_ptr[c_AW-1:0]);
    assign w_do_pop  = i_pop && !o_empty;
    // A pop on the same edge frees the slot, so a push into a full FIFO still lands.
    assign w_do_push = i_push && (!o_full || w_do_pop);
    assign o_rdata   = r_mem[r_rd_ptr[c_AW-1:0]];

    always_ff @(posedge clk) begin
        if (w_do_push) begin
            r_mem[r_wr_ptr[c_AW-1:0]] <= i_wdata;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_do_push) begin
                r_wr_ptr <= r_wr_ptr + (c_AW+1)'(1);
            end
            if (w_do_pop) begin
                r_rd_ptr <= r_rd_ptr + (c_AW+1)'(1);
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/mv_result_packer.sv
`default_nettype none
// ============================================================================
// Module   : mv_result_packer
// Brief    : Packs streamed scalar results into NUM-lane words, buffered for output.
// Revision : 1.0
// ============================================================================
module mv_result_packer
    import mm_pkg::*;
#(
    parameter int NUM   = c_NUM_DEF,
    parameter int DW    = c_DW_DEF,
    parameter int DEPTH = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_start,
    input  logic [15:0]       i_total_len,
    input  logic              i_res_valid,
    input  logic [DW-1:0]     i_res_data,
    output logic              o_out_valid,
    input  logic              i_out_ready,
    output logic [NUM*DW-1:0] o_out_data,
    output logic [NUM-1:0]    o_out_lane_mask,
    output logic              o_out_last,
    output logic              o_busy,
    output logic              o_done,
    output logic              o_overflow
);
    localparam int              c_LW       = $clog2(NUM);
    localparam int              c_WW       = NUM*DW + NUM + 1;
    localparam logic [c_LW-1:0] c_LANE_MAX = c_LW'(NUM-1);

    state_e              r_state;
    logic [15:0]         r_total_len;
    logic [15:0]         r_rcv_cnt;
    logic [c_LW-1:0]     r_lane_cnt;
    logic [NUM*DW-1:0]   r_asm;
    logic [NUM-1:0]      r_mask;
    logic                r_busy;
    logic                r_done;
    logic                r_overflow;

    logic [NUM*DW-1:0]   w_merged;
    logic [NUM-1:0]      w_mask;
    logic [15:0]         w_rcv_next;
    logic                w_is_last;
    logic                w_complete;
    logic                w_push;
    logic                w_pop;
    logic                w_full;
    logic                w_empty;
    logic [c_WW-1:0]     w_push_word;
    logic [c_WW-1:0]     w_head;

    // Current scalar merged into the assembly word; pushed directly when it completes.
    always_comb begin
        w_merged = r_asm;
        w_mask   = r_mask;
        w_merged[lane_lsb(int'(r_lane_cnt), DW) +: DW] = i_res_data;
        w_mask[r_lane_cnt] = 1'b1;
    end

    assign w_rcv_next  = r_rcv_cnt + 16'd1;
    assign w_is_last   = (w_rcv_next == r_total_len);
    assign w_complete  = (r_lane_cnt == c_LANE_MAX) || w_is_last;
    assign w_push      = (r_state == ST_COLLECT) && i_res_valid && w_complete;
    assign w_pop       = o_out_valid && i_out_ready;
    assign w_push_word = {w_is_last, w_mask, w_merged};

    mv_word_fifo #(
        .WIDTH (c_WW),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_push  (w_push),
        .i_wdata (w_push_word),
        .i_pop   (w_pop),
        .o_rdata (w_head),
        .o_full  (w_full),
        .o_empty (w_empty)
    );

    assign o_out_valid     = !w_empty;
    assign o_out_data      = w_empty ? '0   : w_head[NUM*DW-1:0];
    assign o_out_lane_mask = w_empty ? '0   : w_head[NUM*DW +: NUM];
    assign o_out_last      = w_empty ? 1'b0 : w_head[c_WW-1];
    assign o_busy          = r_busy;
    assign o_done          = r_done;
    assign o_overflow      = r_overflow;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= ST_IDLE;
            r_total_len <= '0;
            r_rcv_cnt   <= '0;
            r_lane_cnt  <= '0;
            r_asm       <= '0;
            r_mask      <= '0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_overflow  <= 1'b0;
        end else begin
            r_done <= 1'b0;
            if (w_push && w_full && !w_pop) begin
                r_overflow <= 1'b1;
            end
            case (r_state)
                ST_IDLE: begin
                    if (i_start) begin
                        r_overflow <= 1'b0;
                        if (i_total_len != 16'd0) begin
                            r_total_len <= i_total_len;
                            r_rcv_cnt   <= '0;
                            r_lane_cnt  <= '0;
                            r_asm       <= '0;
                            r_mask      <= '0;
                            r_busy      <= 1'b1;
                            r_state     <= ST_COLLECT;
                        end else begin
                            r_done <= 1'b1;
                        end
                    end
                end
                ST_COLLECT: begin
                    if (i_res_valid) begin
                        r_rcv_cnt <= w_rcv_next;
                        if (w_complete) begin
                            r_asm      <= '0;
                            r_mask     <= '0;
                            r_lane_cnt <= '0;
                            if (w_is_last) begin
                                r_state <= ST_DRAIN;
                            end
                        end else begin
                            r_asm      <= w_merged;
                            r_mask     <= w_mask;
                            r_lane_cnt <= r_lane_cnt + c_LW'(1);
                        end
                    end
                end
                ST_DRAIN: begin
                    if (w_empty) begin
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                        r_state <= ST_IDLE;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_mv_result_packer.sv
`default_nettype none
// ============================================================================
// Module   : tb_mv_result_packer
// Brief    : Random-stimulus bench with a queue-based reference of the packer.
// Revision : 1.0
// ============================================================================
module tb_mv_result_packer;
    localparam int NUM   = 16;
    localparam int DW    = 32;
    localparam int DEPTH = 4;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              i_start = 1'b0;
    logic [15:0]       i_total_len = '0;
    logic              i_res_valid = 1'b0;
    logic [DW-1:0]     i_res_data = '0;
    logic              o_out_valid;
    logic              i_out_ready = 1'b1;
    logic [NUM*DW-1:0] o_out_data;
    logic [NUM-1:0]    o_out_lane_mask;
    logic              o_out_last;
    logic              o_busy;
    logic              o_done;
    logic              o_overflow;

    mv_result_packer #(.NUM(NUM), .DW(DW), .DEPTH(DEPTH)) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .i_start         (i_start),
        .i_total_len     (i_total_len),
        .i_res_valid     (i_res_valid),
        .i_res_data      (i_res_data),
        .o_out_valid     (o_out_valid),
        .i_out_ready     (i_out_ready),
        .o_out_data      (o_out_data),
        .o_out_lane_mask (o_out_lane_mask),
        .o_out_last      (o_out_last),
        .o_busy          (o_busy),
        .o_done          (o_done),
        .o_overflow      (o_overflow)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check_eq(input string tag, input logic [NUM*DW-1:0] obs,
                            input logic [NUM*DW-1:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference: scalars gathered into a list, words formed from whole lists, FIFO as a queue.
    typedef struct {
        logic [NUM*DW-1:0] data;
        logic [NUM-1:0]    mask;
        logic              last;
    } word_t;

    word_t         mq[$];
    logic [DW-1:0] part[$];
    int            m_st   = 0;
    int            m_len  = 0;
    int            m_cnt  = 0;
    logic          m_done = 1'b0;
    logic          m_ovf  = 1'b0;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mq.delete();
            part.delete();
            m_st = 0; m_len = 0; m_cnt = 0; m_done = 1'b0; m_ovf = 1'b0;
        end else begin
            bit    pop;
            word_t w;
            pop    = (mq.size() > 0) && i_out_ready;
            m_done = 1'b0;
            case (m_st)
                0: if (i_start) begin
                    m_ovf = 1'b0;
                    if (i_total_len != 0) begin
                        m_len = int'(i_total_len); m_cnt = 0; part.delete(); m_st = 1;
                    end else m_done = 1'b1;
                end
                1: if (i_res_valid) begin
                    part.push_back(i_res_data);
                    m_cnt++;
                    if (part.size() == NUM || m_cnt == m_len) begin
                        w.data = '0; w.mask = '0;
                        foreach (part[i]) begin
                            w.data[i*DW +: DW] = part[i];
                            w.mask[i] = 1'b1;
                        end
                        w.last = (m_cnt == m_len);
                        if (mq.size() < DEPTH || pop) mq.push_back(w);
                        else m_ovf = 1'b1;
                        part.delete();
                        if (m_cnt == m_len) m_st = 2;
                    end
                end
                2: if (mq.size() == 0) begin
                    m_done = 1'b1; m_st = 0;
                end
                default: m_st = 0;
            endcase
            if (pop) void'(mq.pop_front());
        end
    end

    always @(negedge clk) begin
        check_eq("out_valid", o_out_valid, mq.size() > 0);
        check_eq("busy", o_busy, m_st != 0);
        check_eq("done", o_done, m_done);
        check_eq("overflow", o_overflow, m_ovf);
        if (mq.size() > 0) begin
            check_eq("out_data", o_out_data, mq[0].data);
            check_eq("lane_mask", o_out_lane_mask, mq[0].mask);
            check_eq("out_last", o_out_last, mq[0].last);
        end else begin
            check_eq("idle_data", o_out_data, '0);
        end
    end

    bit rand_ready = 1'b0;

    task automatic tick();
        @(posedge clk);
        #1;
        if (rand_ready) i_out_ready = 1'($urandom_range(0, 1));
    endtask

    task automatic start_job(input int len);
        i_start = 1'b1;
        i_total_len = 16'(len);
        tick();
        i_start = 1'b0;
    endtask

    task automatic send(input logic [DW-1:0] d, input int gap_pct);
        while (int'($urandom_range(0, 99)) < gap_pct) begin
            i_res_valid = 1'b0;
            tick();
        end
        i_res_valid = 1'b1;
        i_res_data  = d;
        tick();
        i_res_valid = 1'b0;
    endtask

    task automatic wait_done(input int budget);
        bit seen = 1'b0;
        for (int c = 0; c < budget && !seen; c++) begin
            if (o_done) seen = 1'b1;
            else tick();
        end
        check_eq("done_seen", seen, 1'b1);
    endtask

    task automatic full_word_job();
        logic [DW-1:0] fp [16] = '{32'h3F800000, 32'h40000000, 32'h40400000, 32'h40800000,
                                   32'h40A00000, 32'h40C00000, 32'h40E00000, 32'h41000000,
                                   32'h41100000, 32'h41200000, 32'h41300000, 32'h41400000,
                                   32'h41500000, 32'h41600000, 32'h41700000, 32'h41800000};
        i_out_ready = 1'b1;
        start_job(16);
        for (int k = 0; k < 16; k++) begin
            if (k == 15) check_eq("valid_before_16th", o_out_valid, 1'b0);
            send(fp[k], 0);
        end
        check_eq("fw_valid", o_out_valid, 1'b1);
        check_eq("fw_lane0", o_out_data[31:0], 32'h3F800000);
        check_eq("fw_lane15", o_out_data[511:480], 32'h41800000);
        check_eq("fw_mask", o_out_lane_mask, 16'hFFFF);
        check_eq("fw_last", o_out_last, 1'b1);
        wait_done(20);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int pops;
        int len;
        #2;
        check_eq("rst_valid", o_out_valid, 1'b0);
        check_eq("rst_busy", o_busy, 1'b0);
        check_eq("rst_done", o_done, 1'b0);
        check_eq("rst_ovf", o_overflow, 1'b0);
        check_eq("rst_data", o_out_data, '0);
        check_eq("rst_mask", o_out_lane_mask, '0);
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        tick();

        full_word_job();

        // Partial tail: one full word, then four lanes.
        i_out_ready = 1'b0;
        start_job(20);
        for (int k = 0; k < 20; k++) send($urandom, 40);
        check_eq("pt_mask0", o_out_lane_mask, 16'hFFFF);
        check_eq("pt_last0", o_out_last, 1'b0);
        i_out_ready = 1'b1;
        tick();
        check_eq("pt_mask1", o_out_lane_mask, 16'h000F);
        check_eq("pt_last1", o_out_last, 1'b1);
        check_eq("pt_zero_lanes", o_out_data[511:128], '0);
        wait_done(20);

        // Overflow: six words into a four-deep FIFO with the sink stalled.
        i_out_ready = 1'b0;
        start_job(96);
        for (int k = 0; k < 96; k++) send($urandom, 20);
        check_eq("ov_sticky", o_overflow, 1'b1);
        check_eq("ov_busy", o_busy, 1'b1);
        i_out_ready = 1'b1;
        pops = 0;
        for (int c = 0; c < 50 && !o_done; c++) begin
            if (o_out_valid) pops++;
            tick();
        end
        check_eq("ov_done", o_done, 1'b1);
        check_eq("ov_pops", pops, 4);

        // Zero-length job with a stray scalar in the start cycle; also clears overflow.
        i_start = 1'b1; i_total_len = 16'd0; i_res_valid = 1'b1; i_res_data = $urandom;
        tick();
        i_start = 1'b0; i_res_valid = 1'b0;
        check_eq("zl_done", o_done, 1'b1);
        check_eq("zl_ovf_clr", o_overflow, 1'b0);
        check_eq("zl_valid", o_out_valid, 1'b0);
        tick();
        check_eq("zl_done_pulse", o_done, 1'b0);

        // Push and pop on the same edge while full.
        i_out_ready = 1'b0;
        start_job(80);
        for (int k = 0; k < 79; k++) send($urandom, 10);
        check_eq("sp_valid", o_out_valid, 1'b1);
        i_out_ready = 1'b1;
        send($urandom, 0);
        check_eq("sp_no_ovf", o_overflow, 1'b0);
        wait_done(50);

        // Ignored inputs: scalars in IDLE and a start pulse during COLLECT.
        repeat (3) begin
            i_res_valid = 1'b1; i_res_data = $urandom;
            tick();
        end
        start_job(16);
        i_res_valid = 1'b0;
        for (int k = 0; k < 5; k++) send($urandom, 0);
        i_start = 1'b1; i_total_len = 16'd3;
        tick();
        i_start = 1'b0;
        for (int k = 0; k < 11; k++) send($urandom, 0);
        wait_done(20);

        // Asynchronous reset mid-job.
        rand_ready = 1'b1;
        start_job(32);
        for (int k = 0; k < 10; k++) send($urandom, 0);
        #2 rst_n = 1'b0;
        #1;
        check_eq("mr_busy", o_busy, 1'b0);
        check_eq("mr_valid", o_out_valid, 1'b0);
        check_eq("mr_data", o_out_data, '0);
        check_eq("mr_mask", o_out_lane_mask, '0);
        check_eq("mr_done", o_done, 1'b0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        rand_ready = 1'b0;
        tick();
        full_word_job();

        // Random jobs with random backpressure and gaps.
        rand_ready = 1'b1;
        for (int j = 0; j < 6; j++) begin
            len = int'($urandom_range(1, 70));
            start_job(len);
            for (int k = 0; k < len; k++) send($urandom, 30);
            wait_done(400);
        end
        rand_ready = 1'b0;
        i_out_ready = 1'b1;
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
